// File: rtl/bnn_frame_loader.sv
// bnn_frame_loader: SPI command frame assembler and BNN load/response sequencer.
// Optional inter-byte timeout built when BNN_FRAME_TIMEOUT_EN is defined.
module bnn_frame_loader #(
  parameter logic [7:0]  HDR_BYTE       = 8'hA5,
  parameter logic [3:0]  ACK_NIBBLE     = 4'h5,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [3:0]  in_bits,
  output logic [15:0] weights,
  output logic [15:0] bias,
  output logic        load,
  input  logic [3:0]  result,
  input  logic        result_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAYLOAD, S_CHECK, S_LOAD, S_WAIT, S_RESP
  } state_t;

  state_t      state_q;
  logic [7:0]  pay_q [5];
  logic [2:0]  cnt_q;
  logic [7:0]  xor_q;
  logic        rx_ready_q;
  logic [3:0]  in_bits_q;
  logic [15:0] weights_q;
  logic [15:0] bias_q;
  logic        load_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic        err_q;

  logic rx_fire;
  logic tmo_hit;

  assign rx_fire   = rx_valid && rx_ready_q;
  assign rx_ready  = rx_ready_q;
  assign in_bits   = in_bits_q;
  assign weights   = weights_q;
  assign bias      = bias_q;
  assign load      = load_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign frame_err = err_q;

`ifdef BNN_FRAME_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          in_frame;

  assign in_frame = (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign tmo_hit  = in_frame && !rx_fire && (tmo_q == TMO_MAX);

  always_comb begin
    tmo_d = '0;
    if (in_frame && !rx_fire && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < 5; i++) pay_q[i] <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      rx_ready_q <= 1'b1;
      in_bits_q  <= '0;
      weights_q  <= '0;
      bias_q     <= '0;
      load_q     <= 1'b0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_fire && rx_byte == HDR_BYTE) begin
            cnt_q   <= '0;
            xor_q   <= '0;
            err_q   <= 1'b0;
            state_q <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (rx_fire) begin
            pay_q[cnt_q] <= rx_byte;
            xor_q        <= xor_q ^ rx_byte;
            cnt_q        <= cnt_q + 3'd1;
            if (cnt_q == 3'd4) state_q <= S_CHECK;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (rx_fire) begin
            rx_ready_q <= 1'b0;
            if (rx_byte == xor_q && pay_q[0][7:4] == 4'h0) begin
              in_bits_q <= pay_q[0][3:0];
              weights_q <= {pay_q[2], pay_q[1]};
              bias_q    <= {pay_q[4], pay_q[3]};
              load_q    <= 1'b1;
              state_q   <= S_LOAD;
            end else begin
              err_q      <= 1'b1;
              tx_byte_q  <= NAK_BYTE;
              tx_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          load_q  <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (result_valid) begin
            tx_byte_q  <= {ACK_NIBBLE, result};
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// tb_bnn_frame_loader: table vectors, hand sequences and randomized
// frames checked against a stream-parsing reference model.
module tb_bnn_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  in_bits;
  logic [15:0] weights;
  logic [15:0] bias;
  logic        load;
  logic [3:0]  result;
  logic        result_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bnn_frame_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .in_bits(in_bits), .weights(weights), .bias(bias), .load(load),
    .result(result), .result_valid(result_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_err(frame_err)
  );

  int          load_cnt = 0;
  logic [3:0]  cap_in;
  logic [15:0] cap_w;
  logic [15:0] cap_b;

  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      cap_in   <= in_bits;
      cap_w    <= weights;
      cap_b    <= bias;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [71:0] bytes, input int n,
                           input logic [3:0] res, input int bp,
                           output int nload, output logic [7:0] gtx,
                           output logic gerr, output logic stable);
    int lc0 = load_cnt;
    int w = 0;
    for (int i = 0; i < n; i++) send_byte(bytes[i*8 +: 8]);
    if (load) begin
      result_valid = 1'b1;
      result = ~res;
      @(negedge clk);
      result = res;
      @(negedge clk);
      result_valid = 1'b0;
    end
    while (!tx_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("tx_valid_timeout", 0, 1);
    gtx = tx_byte;
    gerr = frame_err;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (tx_byte !== gtx || !tx_valid || rx_ready) stable = 1'b0;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    if (tx_valid || !rx_ready) stable = 1'b0;
    @(negedge clk);
    nload = load_cnt - lc0;
  endtask

  task automatic model(input logic [71:0] bytes, input int n,
                       input logic [3:0] res, output logic el,
                       output logic [3:0] ein, output logic [15:0] ew,
                       output logic [15:0] eb, output logic [7:0] etx,
                       output logic eerr);
    logic [7:0] f[$];
    logic [7:0] b;
    logic [7:0] x;
    logic [7:0] p0;
    bit in_frame = 0;
    for (int i = 0; i < n; i++) begin
      b = bytes[i*8 +: 8];
      if (in_frame) f.push_back(b);
      else if (b == 8'hA5) in_frame = 1;
    end
    x = 0;
    for (int i = 0; i < 5; i++) x ^= f[i];
    p0 = f[0];
    el = (f[5] == x) && (p0[7:4] == 4'h0);
    ein = p0[3:0];
    ew = {f[2], f[1]};
    eb = {f[4], f[3]};
    etx = el ? {4'h5, res} : 8'hEE;
    eerr = !el;
  endtask

  typedef struct {
    logic [71:0] bytes;
    int          n;
    logic [3:0]  res;
    int          bp;
    logic        el;
    logic [3:0]  ein;
    logic [15:0] ew;
    logic [15:0] eb;
    logic [7:0]  etx;
    logic        eerr;
  } vec_t;

  vec_t vt[6];

  task automatic check_frame(input string tag, input logic [71:0] bytes,
                             input int n, input logic [3:0] res,
                             input int bp, input logic el,
                             input logic [3:0] ein, input logic [15:0] ew,
                             input logic [15:0] eb, input logic [7:0] etx,
                             input logic eerr);
    int nl;
    logic [7:0] gtx;
    logic gerr;
    logic st;
    run_frame(bytes, n, res, bp, nl, gtx, gerr, st);
    chk({tag, "_loads"}, nl, el ? 1 : 0);
    if (el) begin
      chk({tag, "_in"}, cap_in, ein);
      chk({tag, "_w"}, cap_w, ew);
      chk({tag, "_b"}, cap_b, eb);
    end
    chk({tag, "_tx"}, gtx, etx);
    chk({tag, "_err"}, gerr, eerr);
    chk({tag, "_hs"}, st, 1);
  endtask

  initial begin
    logic [71:0] bytes;
    logic [7:0]  b;
    logic [7:0]  x;
    logic [3:0]  res;
    logic        el, eerr;
    logic [3:0]  ein;
    logic [15:0] ew, eb;
    logic [7:0]  etx;
    int          nj, n;

    vt[0] = '{72'h0B_56_78_12_34_03_A5, 7, 4'h9, 10,
              1, 4'h3, 16'h1234, 16'h5678, 8'h59, 0};
    vt[1] = '{72'h00_56_78_12_34_03_A5, 7, 4'h9, 0,
              0, 4'h0, 16'h0, 16'h0, 8'hEE, 1};
    vt[2] = '{72'h0B_56_78_12_34_03_A5, 7, 4'h2, 0,
              1, 4'h3, 16'h1234, 16'h5678, 8'h52, 0};
    vt[3] = '{72'h01_00_00_00_00_01_A5_FF_00, 9, 4'hA, 3,
              1, 4'h1, 16'h0, 16'h0, 8'h5A, 0};
    vt[4] = '{72'h13_00_00_00_00_13_A5, 7, 4'h1, 0,
              0, 4'h0, 16'h0, 16'h0, 8'hEE, 1};
    vt[5] = '{72'h01_00_00_A5_A5_01_A5, 7, 4'h0, 0,
              1, 4'h1, 16'hA5A5, 16'h0, 8'h50, 0};

    rst_n = 1'b0;
    rx_byte = '0;
    rx_valid = 1'b0;
    result = '0;
    result_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_outs", {load, tx_valid, frame_err, tx_byte, in_bits}, 0);
    chk("rst_wb", {weights, bias}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      check_frame($sformatf("vec%0d", i), vt[i].bytes, vt[i].n, vt[i].res,
                  vt[i].bp, vt[i].el, vt[i].ein, vt[i].ew, vt[i].eb,
                  vt[i].etx, vt[i].eerr);

    check_frame("bad2", vt[1].bytes, 7, 4'h0, 0, 0, 4'h0, 16'h0, 16'h0,
                8'hEE, 1);
    send_byte(8'hA5);
    chk("hdr_clears_err", frame_err, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {load, tx_valid, frame_err, tx_byte, in_bits}, 0);
    chk("mid_rst_wb", {weights, bias}, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("post_rst", vt[0].bytes, 7, 4'h9, 0, 1, 4'h3, 16'h1234,
                16'h5678, 8'h59, 0);

`ifdef BNN_FRAME_TIMEOUT_EN
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (15) @(negedge clk);
    chk("tmo_early", frame_err, 0);
    @(negedge clk);
    chk("tmo_err", frame_err, 1);
    chk("tmo_no_tx", tx_valid, 0);
    chk("tmo_idle", rx_ready, 1);
    check_frame("post_tmo", vt[0].bytes, 7, 4'h9, 0, 1, 4'h3, 16'h1234,
                16'h5678, 8'h59, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      bytes = '0;
      nj = $urandom_range(0, 2);
      n = 0;
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        bytes[n*8 +: 8] = b;
        n++;
      end
      bytes[n*8 +: 8] = 8'hA5;
      n++;
      x = 0;
      for (int j = 0; j < 5; j++) begin
        b = 8'($urandom_range(0, 255));
        if (j == 0 && $urandom_range(0, 3) != 0) b[7:4] = 4'h0;
        bytes[n*8 +: 8] = b;
        x ^= b;
        n++;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      bytes[n*8 +: 8] = x;
      n++;
      res = 4'($urandom_range(0, 15));
      model(bytes, n, res, el, ein, ew, eb, etx, eerr);
      check_frame($sformatf("rnd%0d", t), bytes, n, res,
                  $urandom_range(0, 4), el, ein, ew, eb, etx, eerr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
